// File: rtl/dram_pkg.sv
// Shared types, timing constants and address decode for the DDR4 command issuer.
// The address map places the row in the top bits and ignores the 64-byte line offset.
package dram_pkg;

    localparam int T_RCD   = 24;
    localparam int T_RP    = 24;
    localparam int T_RAS   = 52;
    localparam int T_CL    = 24;
    localparam int T_CWL   = 20;
    localparam int T_BURST = 4;

    localparam int ADDR_W = 33;
    localparam int ROW_W  = 15;
    localparam int COL_W  = 8;
    localparam int BANK_W = 2;
    localparam int BG_W   = 2;
    localparam int WAIT_W = 7;
    localparam int TRAS_W = 7;

    localparam int ROW_LSB  = 18;
    localparam int COL_LSB  = 10;
    localparam int BANK_LSB = 8;
    localparam int BG_LSB   = 6;

    // Wait counters load N-1 and advance on the cycle they read zero.
    localparam logic [WAIT_W-1:0] WAIT_RCD     = WAIT_W'(T_RCD - 1);
    localparam logic [WAIT_W-1:0] WAIT_RP      = WAIT_W'(T_RP - 1);
    localparam logic [WAIT_W-1:0] WAIT_RD_DATA = WAIT_W'(T_CL + T_BURST - 1);
    localparam logic [WAIT_W-1:0] WAIT_WR_DATA = WAIT_W'(T_CWL + T_BURST - 1);
    localparam logic [TRAS_W-1:0] TRAS_LOAD    = TRAS_W'(T_RAS);

    typedef enum logic [2:0] {
        CMD_NOP = 3'd0,
        CMD_ACT = 3'd1,
        CMD_PRE = 3'd2,
        CMD_RD  = 3'd3,
        CMD_WR  = 3'd4
    } cmd_e;

    typedef enum logic [1:0] {
        OP_RD     = 2'd0,
        OP_WR     = 2'd1,
        OP_IFETCH = 2'd2,
        OP_RSVD   = 2'd3
    } op_e;

    typedef struct packed {
        op_e              op;
        logic [BG_W-1:0]  bg;
        logic [BANK_W-1:0] bank;
        logic [ROW_W-1:0] row;
        logic [COL_W-1:0] col;
    } req_t;

    function automatic req_t decode_addr(input op_e op, input logic [ADDR_W-1:0] addr);
        req_t r;
        r.op   = op;
        r.bg   = addr[BG_LSB +: BG_W];
        r.bank = addr[BANK_LSB +: BANK_W];
        r.row  = addr[ROW_LSB +: ROW_W];
        r.col  = addr[COL_LSB +: COL_W];
        return r;
    endfunction

endpackage

// File: rtl/dram_bank_table.sv
// Per-bank open-row state and tRAS countdown for all 16 banks.
// Lookup is combinational; updates land on the same edge the ACT is driven onto the bus.
module dram_bank_table
    import dram_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [BG_W-1:0]   lookup_bg_i,
    input  logic [BANK_W-1:0] lookup_bank_i,
    input  logic [ROW_W-1:0]  lookup_row_i,
    output logic              hit_o,
    output logic              empty_o,
    output logic              conflict_o,
    output logic              tras_ok_o,
    input  logic              act_i,
    input  logic [BG_W-1:0]   act_bg_i,
    input  logic [BANK_W-1:0] act_bank_i,
    input  logic [ROW_W-1:0]  act_row_i
);

    localparam int NBANKS = 16;

    logic              open_q [NBANKS];
    logic [ROW_W-1:0]  row_q  [NBANKS];
    logic [TRAS_W-1:0] tras_q [NBANKS];

    logic [3:0] lookup_idx;
    logic [3:0] act_idx;

    assign lookup_idx = {lookup_bg_i, lookup_bank_i};
    assign act_idx    = {act_bg_i, act_bank_i};

    // NOTE: the table is only 16 entries of flops, so every field is reset; the open
    // bits must clear anyway and resetting row/tRAS keeps lookups X-free after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NBANKS; i++) begin
                open_q[i] <= 1'b0;
                row_q[i]  <= '0;
                tras_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NBANKS; i++) begin
                if (act_i && (act_idx == 4'(i))) begin
                    open_q[i] <= 1'b1;
                    row_q[i]  <= act_row_i;
                    tras_q[i] <= TRAS_LOAD;
                end else if (tras_q[i] != '0) begin
                    tras_q[i] <= tras_q[i] - 1'b1;
                end
            end
        end
    end

    assign hit_o      = open_q[lookup_idx] && (row_q[lookup_idx] == lookup_row_i);
    assign empty_o    = !open_q[lookup_idx];
    assign conflict_o = open_q[lookup_idx] && (row_q[lookup_idx] != lookup_row_i);
    // PRE is registered, so a count of 1 at decision time means tRAS is met when it hits the bus.
    assign tras_ok_o  = (tras_q[lookup_idx] <= TRAS_W'(1));

endmodule

// File: rtl/dram_cmd_issuer.sv
// Pops one request at a time and issues PRE/ACT/RD/WR under an open-page policy,
// then pulses done. All outputs come straight from registers.
module dram_cmd_issuer
    import dram_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    input  logic [1:0]          req_op,
    input  logic [ADDR_W-1:0]   req_addr,
    output logic                req_ready,
    output logic                cmd_valid,
    output logic [2:0]          cmd_type,
    output logic [BG_W-1:0]     cmd_bg,
    output logic [BANK_W-1:0]   cmd_bank,
    output logic [ROW_W-1:0]    cmd_row,
    output logic [COL_W-1:0]    cmd_col,
    output logic                done_valid,
    output logic [1:0]          done_op
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_PRE_WAIT,
        S_RP_WAIT,
        S_RCD_WAIT,
        S_DATA_WAIT,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    req_t               req_q, req_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic               ready_q, ready_d;
    cmd_e               cmd_q, cmd_d;
    logic [BG_W-1:0]    bg_q, bg_d;
    logic [BANK_W-1:0]  bank_q, bank_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic               done_q, done_d;
    op_e                done_op_q, done_op_d;

    logic bank_hit, bank_empty, bank_conflict, bank_tras_ok;
    logic do_pre, do_act, do_cas;

    dram_bank_table u_bank_table (
        .clk           (clk),
        .rst           (rst),
        .lookup_bg_i   (req_q.bg),
        .lookup_bank_i (req_q.bank),
        .lookup_row_i  (req_q.row),
        .hit_o         (bank_hit),
        .empty_o       (bank_empty),
        .conflict_o    (bank_conflict),
        .tras_ok_o     (bank_tras_ok),
        .act_i         (do_act),
        .act_bg_i      (req_q.bg),
        .act_bank_i    (req_q.bank),
        .act_row_i     (req_q.row)
    );

    // NOTE: every variable in this block gets a default before the case, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        wait_d    = (wait_q != '0) ? wait_q - 1'b1 : wait_q;
        cmd_d     = CMD_NOP;
        bg_d      = '0;
        bank_d    = '0;
        row_d     = '0;
        col_d     = '0;
        done_d    = 1'b0;
        done_op_d = OP_RD;
        do_pre    = 1'b0;
        do_act    = 1'b0;
        do_cas    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_valid && ready_q) begin
                    req_d   = decode_addr(op_e'(req_op), req_addr);
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (bank_hit)                         do_cas  = 1'b1;
                else if (bank_empty)                  do_act  = 1'b1;
                else if (bank_conflict && bank_tras_ok) do_pre = 1'b1;
                else                                  state_d = S_PRE_WAIT;
            end
            S_PRE_WAIT:  if (bank_tras_ok) do_pre = 1'b1;
            S_RP_WAIT:   if (wait_q == '0) do_act = 1'b1;
            S_RCD_WAIT:  if (wait_q == '0) do_cas = 1'b1;
            S_DATA_WAIT: begin
                if (wait_q == '0) begin
                    state_d   = S_DONE;
                    done_d    = 1'b1;
                    done_op_d = req_q.op;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (do_pre) begin
            cmd_d   = CMD_PRE;
            bg_d    = req_q.bg;
            bank_d  = req_q.bank;
            wait_d  = WAIT_RP;
            state_d = S_RP_WAIT;
        end
        if (do_act) begin
            cmd_d   = CMD_ACT;
            bg_d    = req_q.bg;
            bank_d  = req_q.bank;
            row_d   = req_q.row;
            wait_d  = WAIT_RCD;
            state_d = S_RCD_WAIT;
        end
        if (do_cas) begin
            cmd_d   = (req_q.op == OP_WR) ? CMD_WR : CMD_RD;
            bg_d    = req_q.bg;
            bank_d  = req_q.bank;
            col_d   = req_q.col;
            wait_d  = (req_q.op == OP_WR) ? WAIT_WR_DATA : WAIT_RD_DATA;
            state_d = S_DATA_WAIT;
        end

        ready_d = (state_d == S_IDLE);
    end

    // NOTE: state is updated with non-blocking assignments so every register samples
    // the pre-edge values computed above, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            req_q     <= '0;
            wait_q    <= '0;
            ready_q   <= 1'b0;
            cmd_q     <= CMD_NOP;
            bg_q      <= '0;
            bank_q    <= '0;
            row_q     <= '0;
            col_q     <= '0;
            done_q    <= 1'b0;
            done_op_q <= OP_RD;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            wait_q    <= wait_d;
            ready_q   <= ready_d;
            cmd_q     <= cmd_d;
            bg_q      <= bg_d;
            bank_q    <= bank_d;
            row_q     <= row_d;
            col_q     <= col_d;
            done_q    <= done_d;
            done_op_q <= done_op_d;
        end
    end

    assign req_ready  = ready_q;
    assign cmd_valid  = (cmd_q != CMD_NOP);
    assign cmd_type   = cmd_q;
    assign cmd_bg     = bg_q;
    assign cmd_bank   = bank_q;
    assign cmd_row    = row_q;
    assign cmd_col    = col_q;
    assign done_valid = done_q;
    assign done_op    = done_op_q;

endmodule

// File: tb/tb_dram_cmd_issuer.sv
// Directed bench for dram_cmd_issuer: logs bus commands and done pulses with cycle
// stamps relative to the accept edge and compares them with hand-computed timing.
module tb_dram_cmd_issuer;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic [1:0]  req_op;
    logic [32:0] req_addr;
    logic        req_ready;
    logic        cmd_valid;
    logic [2:0]  cmd_type;
    logic [1:0]  cmd_bg;
    logic [1:0]  cmd_bank;
    logic [14:0] cmd_row;
    logic [7:0]  cmd_col;
    logic        done_valid;
    logic [1:0]  done_op;

    dram_cmd_issuer dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_ready  (req_ready),
        .cmd_valid  (cmd_valid),
        .cmd_type   (cmd_type),
        .cmd_bg     (cmd_bg),
        .cmd_bank   (cmd_bank),
        .cmd_row    (cmd_row),
        .cmd_col    (cmd_col),
        .done_valid (done_valid),
        .done_op    (done_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int t;
        int bg;
        int bank;
        int row;
        int col;
    } cmd_rec_t;

    cmd_rec_t cmd_log[$];
    int       done_cyc[$];
    int       done_ops[$];
    int       acc_log[$];
    int       cyc = 0;
    int       checks = 0;
    int       failures = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Sampled mid-cycle; an accept seen here happens at the next rising edge.
    always @(negedge clk) begin
        if (cmd_valid)
            cmd_log.push_back('{cyc, int'(cmd_type), int'(cmd_bg), int'(cmd_bank),
                                int'(cmd_row), int'(cmd_col)});
        if (done_valid) begin
            done_cyc.push_back(cyc);
            done_ops.push_back(int'(done_op));
        end
        if (!rst && req_valid && req_ready) acc_log.push_back(cyc + 1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pk(input int t, input int bg, input int bank,
                                       input int row, input int col);
        logic [31:0] v;
        v = {2'b00, t[2:0], bg[1:0], bank[1:0], row[14:0], col[7:0]};
        return v;
    endfunction

    task automatic clear_logs();
        cmd_log.delete();
        done_cyc.delete();
        done_ops.delete();
    endtask

    task automatic send(input int op, input logic [32:0] addr, output int e);
        int n0;
        n0 = acc_log.size();
        e = -1;
        req_valid = 1'b1;
        req_op    = op[1:0];
        req_addr  = addr;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            if (acc_log.size() > n0) begin
                e = acc_log[$];
                break;
            end
        end
        #1 req_valid = 1'b0;
        if (e < 0) check("accept_timeout", 0, 1);
    endtask

    task automatic wait_done(input int n, input int budget);
        for (int i = 0; i < budget && done_cyc.size() < n; i++) begin
            @(posedge clk);
            #1;
        end
        if (done_cyc.size() < n) check("done_timeout", done_cyc.size(), n);
    endtask

    task automatic exp_cmd(input string tag, input int idx, input int e, input int k,
                           input int t, input int bg, input int bank, input int row, input int col);
        if (idx >= cmd_log.size()) begin
            check({tag, "_missing"}, cmd_log.size(), idx + 1);
        end else begin
            check({tag, "_k"}, cmd_log[idx].cyc - e, k);
            check({tag, "_fields"},
                  pk(cmd_log[idx].t, cmd_log[idx].bg, cmd_log[idx].bank, cmd_log[idx].row, cmd_log[idx].col),
                  pk(t, bg, bank, row, col));
        end
    endtask

    task automatic exp_done(input string tag, input int idx, input int e, input int k, input int op);
        if (idx >= done_cyc.size()) begin
            check({tag, "_missing"}, done_cyc.size(), idx + 1);
        end else begin
            check({tag, "_k"}, done_cyc[idx] - e, k);
            check({tag, "_op"}, done_ops[idx], op);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    localparam int ACT = 1, PRE = 2, RD = 3, WR = 4;

    initial begin
        int e;
        int act_a;
        int n_acc0;
        logic [32:0] bank_addrs [4];
        int          bank_bg    [4];
        int          bank_bk    [4];

        rst = 1'b1; req_valid = 1'b0; req_op = 2'd0; req_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", req_ready, 0);
        check("rst_cmd_valid", cmd_valid, 0);
        check("rst_cmd_type", cmd_type, 0);
        check("rst_cmd_fields", {cmd_bg, cmd_bank, cmd_row, cmd_col}, 0);
        check("rst_done", {done_valid, done_op}, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("ready_after_reset", req_ready, 1);

        // Reset in the middle of the ACT->RD wait drops the request silently.
        clear_logs();
        send(0, 33'h0_0008_0000, e);
        while (cyc < e + 10) begin @(posedge clk); #1; end
        exp_cmd("mid_act", 0, e, 1, ACT, 0, 0, 2, 0);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("midrst_ready", req_ready, 0);
        check("midrst_cmd_valid", cmd_valid, 0);
        rst = 1'b0;
        repeat (60) @(posedge clk);
        #1;
        check("midrst_no_cmd", cmd_log.size(), 1);
        check("midrst_no_done", done_cyc.size(), 0);
        check("midrst_ready_after", req_ready, 1);

        // Empty bank read: row 1, bg 0, bank 0, col 0.
        clear_logs();
        send(0, 33'h0_0004_0000, e);
        wait_done(1, 200);
        exp_cmd("empty_act", 0, e, 1, ACT, 0, 0, 1, 0);
        exp_cmd("empty_rd", 1, e, 25, RD, 0, 0, 0, 0);
        exp_done("empty_done", 0, e, 53, 0);
        check("empty_ncmd", cmd_log.size(), 2);

        // Same-row write, column 5: page hit.
        clear_logs();
        send(1, 33'h0_0004_1400, e);
        wait_done(1, 200);
        exp_cmd("hit_wr", 0, e, 1, WR, 0, 0, 0, 5);
        exp_done("hit_wr_done", 0, e, 25, 1);
        check("hit_wr_ncmd", cmd_log.size(), 1);

        // Empty write to bank 1 row 3, then an immediate conflict read to row 4.
        clear_logs();
        send(1, 33'h0_000C_0100, e);
        wait_done(1, 200);
        exp_cmd("b1_act", 0, e, 1, ACT, 0, 1, 3, 0);
        exp_cmd("b1_wr", 1, e, 25, WR, 0, 1, 0, 0);
        exp_done("b1_done", 0, e, 49, 1);
        act_a = (cmd_log.size() > 0) ? cmd_log[0].cyc : 0;

        clear_logs();
        send(0, 33'h0_0010_0100, e);
        wait_done(1, 300);
        // Accepted 50 cycles after the ACT, so PRE waits one extra cycle for tRAS.
        exp_cmd("cf_pre", 0, e, 2, PRE, 0, 1, 0, 0);
        if (cmd_log.size() > 0) check("cf_tras_gap", cmd_log[0].cyc - act_a, 52);
        exp_cmd("cf_act", 1, e, 26, ACT, 0, 1, 4, 0);
        exp_cmd("cf_rd", 2, e, 50, RD, 0, 1, 0, 0);
        exp_done("cf_done", 0, e, 78, 0);
        check("cf_ncmd", cmd_log.size(), 3);

        // Four fresh banks in different groups: ACT + RD each, never a PRE.
        bank_addrs[0] = 33'h0_001C_0040; bank_bg[0] = 1; bank_bk[0] = 0;
        bank_addrs[1] = 33'h0_001C_0180; bank_bg[1] = 2; bank_bk[1] = 1;
        bank_addrs[2] = 33'h0_001C_02C0; bank_bg[2] = 3; bank_bk[2] = 2;
        bank_addrs[3] = 33'h0_001C_0340; bank_bg[3] = 1; bank_bk[3] = 3;
        for (int i = 0; i < 4; i++) begin
            clear_logs();
            send(0, bank_addrs[i], e);
            wait_done(1, 200);
            exp_cmd($sformatf("bk%0d_act", i), 0, e, 1, ACT, bank_bg[i], bank_bk[i], 7, 0);
            exp_cmd($sformatf("bk%0d_rd", i), 1, e, 25, RD, bank_bg[i], bank_bk[i], 0, 0);
            check($sformatf("bk%0d_ncmd", i), cmd_log.size(), 2);
        end
        // bg3/bank2 row 7 is still open: column 3 read hits.
        clear_logs();
        send(0, 33'h0_001C_0EC0, e);
        wait_done(1, 200);
        exp_cmd("open_hit_rd", 0, e, 1, RD, 3, 2, 0, 3);
        exp_done("open_hit_done", 0, e, 29, 0);

        // ifetch then reserved op with req_valid held high: exactly one pop per done.
        clear_logs();
        n_acc0    = acc_log.size();
        req_op    = 2'd2;
        req_addr  = 33'h0_0004_2400;
        req_valid = 1'b1;
        wait_done(1, 200);
        req_op = 2'd3;
        wait_done(2, 200);
        req_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("cont_pops", acc_log.size() - n_acc0, 2);
        if (acc_log.size() - n_acc0 >= 2) begin
            exp_cmd("cont_rd0", 0, acc_log[n_acc0], 1, RD, 0, 0, 0, 9);
            exp_cmd("cont_rd1", 1, acc_log[n_acc0 + 1], 1, RD, 0, 0, 0, 9);
            exp_done("cont_done0", 0, acc_log[n_acc0], 29, 2);
            exp_done("cont_done1", 1, acc_log[n_acc0 + 1], 29, 3);
            if (done_cyc.size() > 0) check("cont_gap", acc_log[n_acc0 + 1] - done_cyc[0], 2);
        end
        check("cont_ndone", done_cyc.size(), 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
